lcd_reader: RTL and testbench
=============================

Name: lcd_reader

Overview:
- Performs read transactions from the Spartan-3E character LCD over its 4-bit interface (lcd_rw=1), the read-side counterpart of the existing write/command path.
- Each transaction returns one byte from two E-strobed nibble reads, high nibble first: either busy-flag/address (rs=0) or DDRAM/CGRAM data (rs=1).
- Optional poll mode repeats busy-flag reads until BF clears or a retry limit is hit, which lets the controller replace fixed delays with busy polling.
- Outputs feed the top-level LCD mux. The top level disables FPGA sf_d drivers whenever the selected lcd_rw=1.

Parameters:
- T_AS, 2, cycles of rs/rw setup before each E rise (40 ns at 50 MHz)
- T_EH, 12, cycles E is held high per nibble (240 ns)
- T_GAP, 50, cycles E is held low between nibbles and between poll retries (1 us)
- T_HOLD, 2, cycles rs/rw are held after the final E fall
- MAX_POLLS, 255, maximum busy-flag reads in poll mode before timeout (1..255)

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a transaction; sampled only while ready=1
- rs_in  input  1  register select for a non-poll read (0 = BF/address, 1 = data)
- poll_in  input  1  1 = busy-poll mode (forces rs=0)
- sf_d_in  input  4  LCD data bus as read back from the pads
- lcd_rs  output  1  LCD register select
- lcd_rw  output  1  LCD read/write; 1 during a transaction
- lcd_e  output  1  LCD enable strobe
- data_out  output  8  last byte read, {high nibble, low nibble}
- data_valid  output  1  one-cycle pulse when data_out updates
- timeout  output  1  valid with data_valid; 1 = poll limit reached with BF still set
- ready  output  1  high in IDLE, when start is accepted

Behaviour:
- Reset (async, rst_n=0), all registers asserted immediately:
  - FSM=IDLE; lcd_e=0, lcd_rs=0, lcd_rw=1; data_out=0x00; data_valid=0; timeout=0; ready=1; counters=0.
  - Reset mid-transaction drops lcd_e the same instant and discards the partial byte.
- States: IDLE, SETUP, E1, GAP, E2, HOLD, RETRY, DONE.
- IDLE:
  - ready=1, lcd_e=0.
  - On start=1: latch rs_q = rs_in & ~poll_in and poll_q = poll_in, clear poll_cnt, go to SETUP. ready falls on the next cycle.
  - start while ready=0 is ignored.
- SETUP: lcd_rs=rs_q, lcd_rw=1, lcd_e=0 for T_AS cycles, then E1.
- E1:
  - lcd_e=1 for T_EH cycles.
  - On the last E-high cycle, capture sf_d_in into byte[7:4]. Then go to GAP.
- GAP: lcd_e=0 for T_GAP cycles; rs/rw held. Then E2.
- E2: lcd_e=1 for T_EH cycles; capture sf_d_in into byte[3:0] on the last cycle. Then HOLD.
- HOLD: lcd_e=0 for T_HOLD cycles; rs/rw held. Then:
  - non-poll: go to DONE.
  - poll, byte[7]=0: go to DONE with timeout=0.
  - poll, byte[7]=1 and poll_cnt+1 < MAX_POLLS: increment poll_cnt, go to RETRY.
  - poll, byte[7]=1 and poll_cnt+1 = MAX_POLLS: go to DONE with timeout=1.
- RETRY: lcd_e=0 for T_GAP cycles, then SETUP. No data_valid is generated.
- DONE (1 cycle):
  - data_out<=byte, data_valid=1, timeout set as above.
  - lcd_rs=0, lcd_rw=1.
  - Next state is IDLE, with ready=1 on the following cycle.
- Latency, non-poll: start sampled at cycle 0 → data_valid at cycle T_AS+2*T_EH+T_GAP+T_HOLD+1 (79 with defaults).
  - Each poll retry adds T_GAP+T_AS+2*T_EH+T_GAP+T_HOLD cycles.
- Widths and counters:
  - Delay counter is 8 bits; T_* parameters are 1..255.
  - poll_cnt is 8 bits and never wraps.
- Invariants:
  - lcd_e never goes high unless lcd_rw=1.
  - lcd_e high pulses are exactly T_EH cycles.
  - data_out changes only on data_valid.
  - timeout=0 for non-poll reads.

Test Plan:
- Data read: rs_in=1, poll_in=0, sf_d_in returns 0x4 during E1 and 0x1 during E2 → lcd_rs=1 throughout, two 12-cycle E pulses separated by 50 low cycles, data_valid at cycle 79, data_out=0x41, timeout=0.
- BF/address read: rs_in=1, poll_in=1, bus returns 0x0 then 0x5 → lcd_rs=0 (poll forces rs=0), data_out=0x05, single transaction, timeout=0.
- Poll with busy: BF=1 (nibble 0x8) on the first 3 reads, then 0x0/0x3 → exactly 4 E1/E2 pairs, one data_valid, data_out=0x03, timeout=0.
- Poll timeout: MAX_POLLS=4, bus held at 0x8 → exactly 4 reads, then data_valid with data_out=0x88, timeout=1; ready returns high.
- Start while busy: pulse start at cycles 10 and 40 of a transaction → ignored, exactly one data_valid. A start on the cycle after ready re-asserts is accepted.
- Async reset mid-E1: drop rst_n between clock edges while lcd_e=1 → lcd_e=0 immediately, data_out=0x00, ready=1. A fresh read afterwards completes normally.

Source files
------------

// File: rtl/lcd_reader_if.sv
// Handshake and pad-side signal bundle for the LCD read engine.
// master = controller/testbench side, slave = lcd_reader.
interface lcd_reader_if;
  logic       start;
  logic       rs_in;
  logic       poll_in;
  logic [3:0] sf_d_in;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] data_out;
  logic       data_valid;
  logic       timeout;
  logic       ready;

  modport master (
    output start, rs_in, poll_in, sf_d_in,
    input  lcd_rs, lcd_rw, lcd_e, data_out, data_valid, timeout, ready
  );

  modport slave (
    input  start, rs_in, poll_in, sf_d_in,
    output lcd_rs, lcd_rw, lcd_e, data_out, data_valid, timeout, ready
  );
endinterface

// File: rtl/lcd_reader.sv
// Spartan-3E character LCD 4-bit read engine: two E-strobed nibble reads per byte,
// with optional busy-flag polling bounded by MAX_POLLS.
module lcd_reader #(
  parameter int unsigned T_AS      = 2,
  parameter int unsigned T_EH      = 12,
  parameter int unsigned T_GAP     = 50,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned MAX_POLLS = 255
) (
  input logic         clk,
  input logic         rst_n,
  lcd_reader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, E1, GAP, E2, HOLD, RETRY, DONE} state_t;

  localparam logic [7:0] AS_L   = 8'(T_AS - 1);
  localparam logic [7:0] EH_L   = 8'(T_EH - 1);
  localparam logic [7:0] GAP_L  = 8'(T_GAP - 1);
  localparam logic [7:0] HOLD_L = 8'(T_HOLD - 1);
  localparam logic [8:0] MAXP   = 9'(MAX_POLLS);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] poll_cnt;
  logic       poll_q;
  logic [7:0] byte_q;
  logic       to_q;

  // This block only ever reads, so the pad drivers stay off for its whole life.
  assign bus.lcd_rw = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      poll_cnt       <= '0;
      poll_q         <= 1'b0;
      byte_q         <= '0;
      to_q           <= 1'b0;
      bus.lcd_e      <= 1'b0;
      bus.lcd_rs     <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.ready      <= 1'b1;
    end else begin
      bus.data_valid <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bus.lcd_rs <= bus.rs_in & ~bus.poll_in;
          poll_q     <= bus.poll_in;
          poll_cnt   <= '0;
          cnt        <= '0;
          bus.ready  <= 1'b0;
          state      <= SETUP;
        end
        SETUP: if (cnt == AS_L) begin
          cnt       <= '0;
          bus.lcd_e <= 1'b1;
          state     <= E1;
        end else cnt <= cnt + 8'd1;
        E1: if (cnt == EH_L) begin
          byte_q[7:4] <= bus.sf_d_in;
          cnt         <= '0;
          bus.lcd_e   <= 1'b0;
          state       <= GAP;
        end else cnt <= cnt + 8'd1;
        GAP: if (cnt == GAP_L) begin
          cnt       <= '0;
          bus.lcd_e <= 1'b1;
          state     <= E2;
        end else cnt <= cnt + 8'd1;
        E2: if (cnt == EH_L) begin
          byte_q[3:0] <= bus.sf_d_in;
          cnt         <= '0;
          bus.lcd_e   <= 1'b0;
          state       <= HOLD;
        end else cnt <= cnt + 8'd1;
        HOLD: if (cnt == HOLD_L) begin
          cnt <= '0;
          // BF still set: retry unless this read used up the poll budget.
          if (poll_q && byte_q[7] && (({1'b0, poll_cnt} + 9'd1) < MAXP)) begin
            poll_cnt <= poll_cnt + 8'd1;
            state    <= RETRY;
          end else begin
            to_q       <= poll_q & byte_q[7];
            bus.lcd_rs <= 1'b0;
            state      <= DONE;
          end
        end else cnt <= cnt + 8'd1;
        RETRY: if (cnt == GAP_L) begin
          cnt   <= '0;
          state <= SETUP;
        end else cnt <= cnt + 8'd1;
        DONE: begin
          bus.data_out   <= byte_q;
          bus.data_valid <= 1'b1;
          bus.timeout    <= to_q;
          bus.ready      <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: an LCD nibble responder, a scoreboard queue of
// expected bytes popped by a data_valid monitor, and E-pulse shape checks.
module tb_lcd_reader;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   e_pulses = 0;
  int   e_run = 0;
  logic exp_rs = 1'b0;
  logic [3:0] nib_q[$];
  logic [8:0] exp_q[$];

  lcd_reader_if bus();

  lcd_reader #(.T_AS(2), .T_EH(12), .T_GAP(50), .T_HOLD(2), .MAX_POLLS(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // LCD model: presents the next queued nibble as each E pulse begins.
  always @(posedge bus.lcd_e) if (nib_q.size() > 0) bus.sf_d_in = nib_q.pop_front();

  // E pulse width, rs and rw checked at every falling edge of E.
  always @(negedge clk) begin
    if (!rst_n) e_run = 0;
    else if (bus.lcd_e) e_run++;
    else if (e_run > 0) begin
      chk("e_width", e_run, 12);
      chk("rs_during_e", int'(bus.lcd_rs), int'(exp_rs));
      chk("rw_during_e", int'(bus.lcd_rw), 1);
      e_pulses++;
      e_run = 0;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && bus.data_valid) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("data_out", int'(bus.data_out), int'(e[8:1]));
        chk("timeout", int'(bus.timeout), int'(e[0]));
      end
    end
  end

  task automatic do_read(input logic rs, input logic poll, input logic [31:0] nibs,
                         input int nn, input logic [7:0] ed, input logic eto,
                         input int epulse, input int elat, input bit glitch);
    int w;
    int t0;
    w = 0;
    while (!bus.ready && w < 1000) begin @(negedge clk); w++; end
    if (!bus.ready) begin chk("ready_wait", 0, 1); return; end
    for (int i = 0; i < nn; i++) nib_q.push_back(nibs[31-4*i -: 4]);
    exp_q.push_back({ed, eto});
    exp_rs = rs & ~poll;
    e_pulses = 0;
    bus.rs_in = rs; bus.poll_in = poll; bus.start = 1'b1; t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ready_fall", int'(bus.ready), 0);
    if (glitch) begin
      repeat (9) @(negedge clk);
      bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
      repeat (29) @(negedge clk);
      bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    end
    w = 0;
    while (!bus.data_valid && w < 3000) begin @(negedge clk); w++; end
    if (!bus.data_valid) chk("valid_wait", 0, 1);
    else begin
      chk("e_pulse_count", e_pulses, epulse);
      chk("ready_back", int'(bus.ready), 1);
      if (elat > 0) chk("latency", cyc - t0 - 1, elat);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.rs_in = 1'b0; bus.poll_in = 1'b0; bus.sf_d_in = 4'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_lcd_e", int'(bus.lcd_e), 0);
    chk("rst_lcd_rw", int'(bus.lcd_rw), 1);
    chk("rst_lcd_rs", int'(bus.lcd_rs), 0);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_data_out", int'(bus.data_out), 0);
    chk("rst_valid", int'(bus.data_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // data read 0x41
    do_read(1'b1, 1'b0, 32'h4100_0000, 2, 8'h41, 1'b0, 2, 79, 1'b0);
    // BF/address read, poll forces rs=0
    do_read(1'b1, 1'b1, 32'h0500_0000, 2, 8'h05, 1'b0, 2, 79, 1'b0);
    // busy three times, then clear
    do_read(1'b0, 1'b1, 32'h8080_8003, 8, 8'h03, 1'b0, 8, 0, 1'b0);
    // busy forever -> timeout after 4 reads
    do_read(1'b0, 1'b1, 32'h8888_8888, 8, 8'h88, 1'b1, 8, 0, 1'b0);
    // start while busy ignored, then back-to-back start accepted
    do_read(1'b1, 1'b0, 32'h9C00_0000, 2, 8'h9C, 1'b0, 2, 79, 1'b1);
    do_read(1'b1, 1'b0, 32'h7E00_0000, 2, 8'h7E, 1'b0, 2, 79, 1'b0);

    // async reset in the middle of the first E pulse
    nib_q.push_back(4'h4); nib_q.push_back(4'h1);
    exp_rs = 1'b1;
    bus.rs_in = 1'b1; bus.poll_in = 1'b0; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    begin
      int w;
      w = 0;
      while (!bus.lcd_e && w < 100) begin @(negedge clk); w++; end
      chk("e1_reached", int'(bus.lcd_e), 1);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_lcd_e", int'(bus.lcd_e), 0);
    chk("rst_mid_data_out", int'(bus.data_out), 0);
    chk("rst_mid_ready", int'(bus.ready), 1);
    nib_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(1'b0, 1'b0, 32'h2A00_0000, 2, 8'h2A, 1'b0, 2, 79, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
